// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: forwarding-source encodings and scoreboard sizing defaults.
package riscv_pipe_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_EX = 2'd1;
  localparam logic [1:0] FWD_MA = 2'd2;

  localparam int CNT_W_DEF  = 2;
  localparam int REG_SZ_DEF = 32;

endpackage

// File: rtl/id_scoreboard_if.sv
// Decode-to-scoreboard bundle: issue request, EX/MA retirements and the hazard verdict.
interface id_scoreboard_if #(
    parameter int REG_SZ = 32
);
    logic              id_valid;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [4:0]        id_rd;
    logic              id_rd_we;
    logic              ex_ack;
    logic [4:0]        ex_idx;
    logic [REG_SZ-1:0] ex_val;
    logic              ma_ack;
    logic [4:0]        ma_idx;
    logic [REG_SZ-1:0] ma_val;
    logic              flush;

    logic              id_issue;
    logic              id_stall;
    logic [1:0]        fwd_sel1;
    logic [1:0]        fwd_sel2;
    logic [REG_SZ-1:0] fwd_val1;
    logic [REG_SZ-1:0] fwd_val2;
    logic              busy;
    logic              err;
    logic [31:0]       stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
               ex_ack, ex_idx, ex_val, ma_ack, ma_idx, ma_val, flush,
        input  id_issue, id_stall, fwd_sel1, fwd_sel2, fwd_val1, fwd_val2,
               busy, err, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd, id_rd_we,
               ex_ack, ex_idx, ex_val, ma_ack, ma_idx, ma_val, flush,
        output id_issue, id_stall, fwd_sel1, fwd_sel2, fwd_val1, fwd_val2,
               busy, err, stall_cnt
    );
endinterface

// File: rtl/id_scoreboard_hazard_src_check.sv
// Per-source hazard check: decides readiness and picks RF, EX or MA as the operand source.
module hazard_src_check
    import riscv_pipe_pkg::*;
#(
    parameter int REG_SZ = REG_SZ_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic [4:0]        idx,
    input  logic              use_src,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              ex_ack,
    input  logic [4:0]        ex_idx,
    input  logic [REG_SZ-1:0] ex_val,
    input  logic              ma_ack,
    input  logic [4:0]        ma_idx,
    input  logic [REG_SZ-1:0] ma_val,
    output logic              ready,
    output logic [1:0]        sel,
    output logic [REG_SZ-1:0] val
);
    logic             used;
    logic             ex_hit;
    logic             ma_hit;
    logic [CNT_W:0]   ret_w;

    assign used   = use_src && (idx != 5'd0);
    assign ex_hit = ex_ack && (ex_idx == idx);
    assign ma_hit = ma_ack && (ma_idx == idx);
    assign ret_w  = (CNT_W+1)'(ex_hit) + (CNT_W+1)'(ma_hit);

    // Ready once every outstanding write to this register retires no later than now.
    assign ready = !used || ({1'b0, cnt} <= ret_w);

    // NOTE: give every always_comb output a default first so no path infers a latch.
    always_comb begin
        sel = FWD_RF;
        val = '0;
        if (used && ex_hit) begin
            sel = FWD_EX;
            val = ex_val;
        end else if (used && ma_hit) begin
            sel = FWD_MA;
            val = ma_val;
        end
    end
endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard: per-register pending-write counters, issue/stall and forwarding.
module id_scoreboard
    import riscv_pipe_pkg::*;
#(
    parameter int REG_SZ = REG_SZ_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic           clk,
    input logic           rst,
    id_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt      [32];
    logic [CNT_W-1:0] cnt_next [32];
    logic             ex_ack_g;
    logic             ma_ack_g;
    logic             ready1;
    logic             ready2;
    logic             rd_full;
    logic             err_set;
    logic             busy_c;
    logic             err_q;
    logic [31:0]      stall_q;

    // Retirements seen while reset is held must not leak into forwarding or counters.
    assign ex_ack_g = sb.ex_ack & ~rst;
    assign ma_ack_g = sb.ma_ack & ~rst;

    hazard_src_check #(.REG_SZ(REG_SZ), .CNT_W(CNT_W)) u_src1 (
        .idx     (sb.id_rs1),
        .use_src (sb.id_use_rs1),
        .cnt     (cnt[sb.id_rs1]),
        .ex_ack  (ex_ack_g),
        .ex_idx  (sb.ex_idx),
        .ex_val  (sb.ex_val),
        .ma_ack  (ma_ack_g),
        .ma_idx  (sb.ma_idx),
        .ma_val  (sb.ma_val),
        .ready   (ready1),
        .sel     (sb.fwd_sel1),
        .val     (sb.fwd_val1)
    );

    hazard_src_check #(.REG_SZ(REG_SZ), .CNT_W(CNT_W)) u_src2 (
        .idx     (sb.id_rs2),
        .use_src (sb.id_use_rs2),
        .cnt     (cnt[sb.id_rs2]),
        .ex_ack  (ex_ack_g),
        .ex_idx  (sb.ex_idx),
        .ex_val  (sb.ex_val),
        .ma_ack  (ma_ack_g),
        .ma_idx  (sb.ma_idx),
        .ma_val  (sb.ma_val),
        .ready   (ready2),
        .sel     (sb.fwd_sel2),
        .val     (sb.fwd_val2)
    );

    // A saturated destination may only take another write if one retires this cycle.
    assign rd_full = sb.id_rd_we && (sb.id_rd != 5'd0) && (cnt[sb.id_rd] == CNT_MAX)
                   && !(ex_ack_g && (sb.ex_idx == sb.id_rd))
                   && !(ma_ack_g && (sb.ma_idx == sb.id_rd));

    assign sb.id_issue  = sb.id_valid & ready1 & ready2 & ~rd_full & ~sb.flush;
    assign sb.id_stall  = sb.id_valid & ~sb.id_issue;
    assign sb.busy      = busy_c;
    assign sb.err       = err_q;
    assign sb.stall_cnt = stall_q;

    always_comb begin
        logic [CNT_W:0] ret_w;
        logic [CNT_W:0] inc_w;
        logic [CNT_W:0] base_w;
        logic [CNT_W:0] sum_w;
        err_set = 1'b0;
        busy_c  = 1'b0;
        for (int r = 0; r < 32; r++) begin
            ret_w  = (CNT_W+1)'(ex_ack_g && (sb.ex_idx == 5'(r)))
                   + (CNT_W+1)'(ma_ack_g && (sb.ma_idx == 5'(r)));
            inc_w  = (CNT_W+1)'(sb.id_issue && sb.id_rd_we && (sb.id_rd == 5'(r)));
            base_w = {1'b0, cnt[r]};
            sum_w  = base_w - ret_w + inc_w;
            busy_c = busy_c | (cnt[r] != '0);
            cnt_next[r] = cnt[r];
            if (r == 0) begin
                cnt_next[r] = '0;
            end else if (sb.flush) begin
                cnt_next[r] = '0;
            end else if (ret_w > base_w) begin
                cnt_next[r] = '0;
                err_set     = 1'b1;
            end else if (sum_w > {1'b0, CNT_MAX}) begin
                cnt_next[r] = CNT_MAX;
                err_set     = 1'b1;
            end else begin
                cnt_next[r] = sum_w[CNT_W-1:0];
            end
        end
    end

    // NOTE: the counter array is reset explicitly; pending state must vanish the moment rst rises.
    // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            cnt     <= cnt_next;
            err_q   <= err_q | err_set;
            stall_q <= stall_q + 32'(sb.id_stall);
        end
    end
endmodule

// File: tb/tb_id_scoreboard.sv
// Self-checking bench for id_scoreboard: per-cycle vector table through an expected-result queue,
// then hand-written stall-counter and mid-operation reset sequences.
module tb_id_scoreboard;
    import riscv_pipe_pkg::*;

    typedef struct {
        string       nm;
        logic        v;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        exa;
        logic [4:0]  exi;
        logic [31:0] exv;
        logic        maa;
        logic [4:0]  mai;
        logic [31:0] mav;
        logic        fl;
        logic        iss;
        logic [1:0]  s1;
        logic [31:0] v1;
        logic [1:0]  s2;
        logic [31:0] v2;
        logic        busy;
        logic        err;
    } vec_t;

    typedef struct {
        string       nm;
        logic        iss;
        logic        stl;
        logic [1:0]  s1;
        logic [31:0] v1;
        logic [1:0]  s2;
        logic [31:0] v2;
        logic        busy;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vecs[$];
    exp_t expq[$];

    always #5 clk = ~clk;

    id_scoreboard_if #(.REG_SZ(32)) sbi ();

    id_scoreboard #(.REG_SZ(32), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbi.slave)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    function automatic vec_t mk(
        input string nm, input logic v,
        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
        input logic [4:0] rd, input logic we,
        input logic exa, input logic [4:0] exi, input logic [31:0] exv,
        input logic maa, input logic [4:0] mai, input logic [31:0] mav,
        input logic fl, input logic iss,
        input logic [1:0] s1, input logic [31:0] v1, input logic [1:0] s2, input logic [31:0] v2,
        input logic busy, input logic err);
        vec_t t;
        t.nm = nm; t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.we = we; t.exa = exa; t.exi = exi; t.exv = exv;
        t.maa = maa; t.mai = mai; t.mav = mav; t.fl = fl; t.iss = iss;
        t.s1 = s1; t.v1 = v1; t.s2 = s2; t.v2 = v2; t.busy = busy; t.err = err;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        sbi.id_valid = t.v;  sbi.id_rs1 = t.rs1; sbi.id_use_rs1 = t.u1;
        sbi.id_rs2 = t.rs2;  sbi.id_use_rs2 = t.u2;
        sbi.id_rd = t.rd;    sbi.id_rd_we = t.we;
        sbi.ex_ack = t.exa;  sbi.ex_idx = t.exi; sbi.ex_val = t.exv;
        sbi.ma_ack = t.maa;  sbi.ma_idx = t.mai; sbi.ma_val = t.mav;
        sbi.flush = t.fl;
    endtask

    task automatic push_exp(input vec_t t);
        exp_t e;
        e.nm = t.nm; e.iss = t.iss; e.stl = t.v & ~t.iss;
        e.s1 = t.s1; e.v1 = t.v1; e.s2 = t.s2; e.v2 = t.v2;
        e.busy = t.busy; e.err = t.err;
        expq.push_back(e);
    endtask

    task automatic compare_head();
        exp_t e;
        if (expq.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
            return;
        end
        e = expq.pop_front();
        check({e.nm, ".issue"}, 32'(sbi.id_issue), 32'(e.iss));
        check({e.nm, ".stall"}, 32'(sbi.id_stall), 32'(e.stl));
        check({e.nm, ".sel1"},  32'(sbi.fwd_sel1), 32'(e.s1));
        check({e.nm, ".val1"},  sbi.fwd_val1,      e.v1);
        check({e.nm, ".sel2"},  32'(sbi.fwd_sel2), 32'(e.s2));
        check({e.nm, ".val2"},  sbi.fwd_val2,      e.v2);
        check({e.nm, ".busy"},  32'(sbi.busy),     32'(e.busy));
        check({e.nm, ".err"},   32'(sbi.err),      32'(e.err));
    endtask

    initial begin
        vec_t idle;
        idle = mk("idle", 0, 0,0, 0,0, 0,0, 0,0,0, 0,0,0, 0, 0, FWD_RF,0, FWD_RF,0, 0,0);
        drive(idle);

        //         name            v rs1 u1 rs2 u2 rd we  exa exi exv       maa mai mav        fl iss  s1     v1          s2     v2      busy err
        vecs.push_back(mk("reset_idle",   0, 0,0,  0,0,  0,0,  0,0,0,        0,0,0,         0, 0, FWD_RF,0,          FWD_RF,0,     0,0));
        vecs.push_back(mk("addi_x5",      1, 1,1,  0,0,  5,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,0));
        vecs.push_back(mk("raw_x5_stall", 1, 5,1,  0,0,  6,1,  0,0,0,        0,0,0,         0, 0, FWD_RF,0,          FWD_RF,0,     1,0));
        vecs.push_back(mk("ex_fwd_x5",    1, 5,1,  0,0,  0,0,  1,5,32'h1234, 0,0,0,         0, 1, FWD_EX,32'h1234,   FWD_RF,0,     1,0));
        vecs.push_back(mk("rf_x5",        1, 5,1,  0,0,  0,0,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,0));
        vecs.push_back(mk("wr_x7_a",      1, 0,0,  0,0,  7,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,0));
        vecs.push_back(mk("wr_x7_b",      1, 0,0,  0,0,  7,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     1,0));
        vecs.push_back(mk("dual_ret_x7",  1, 0,0,  7,1,  0,0,  1,7,32'hBB,   1,7,32'hAA,    0, 1, FWD_RF,0,          FWD_EX,32'hBB,1,0));
        vecs.push_back(mk("rf_x7",        1, 0,0,  7,1,  0,0,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,0));
        vecs.push_back(mk("wr_x3_1",      1, 0,0,  0,0,  3,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,0));
        vecs.push_back(mk("wr_x3_2",      1, 0,0,  0,0,  3,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     1,0));
        vecs.push_back(mk("wr_x3_3",      1, 0,0,  0,0,  3,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     1,0));
        vecs.push_back(mk("full_x3",      1, 0,0,  0,0,  3,1,  0,0,0,        0,0,0,         0, 0, FWD_RF,0,          FWD_RF,0,     1,0));
        vecs.push_back(mk("full_x3_ret",  1, 0,0,  0,0,  3,1,  1,3,32'h33,   0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     1,0));
        vecs.push_back(mk("full_x3_hold", 1, 0,0,  0,0,  3,1,  0,0,0,        0,0,0,         0, 0, FWD_RF,0,          FWD_RF,0,     1,0));
        vecs.push_back(mk("drain_x3_a",   0, 0,0,  0,0,  0,0,  1,3,32'h1,    1,3,32'h2,     0, 0, FWD_RF,0,          FWD_RF,0,     1,0));
        vecs.push_back(mk("drain_x3_b",   0, 0,0,  0,0,  0,0,  1,3,32'h3,    0,0,0,         0, 0, FWD_RF,0,          FWD_RF,0,     1,0));
        vecs.push_back(mk("rf_x3",        1, 3,1,  0,0,  0,0,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,0));
        vecs.push_back(mk("ma_under_x9",  0, 0,0,  0,0,  0,0,  0,0,0,        1,9,32'h99,    0, 0, FWD_RF,0,          FWD_RF,0,     0,0));
        vecs.push_back(mk("err_sticky",   1, 9,1,  0,0,  0,0,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,1));
        vecs.push_back(mk("wr_x4_a",      1, 0,0,  0,0,  4,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,1));
        vecs.push_back(mk("wr_x4_b",      1, 0,0,  0,0,  4,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     1,1));
        vecs.push_back(mk("flush",        1, 1,1,  0,0,  0,0,  1,4,32'h44,   0,0,0,         1, 0, FWD_RF,0,          FWD_RF,0,     1,1));
        vecs.push_back(mk("post_flush",   0, 0,0,  0,0,  0,0,  0,0,0,        0,0,0,         0, 0, FWD_RF,0,          FWD_RF,0,     0,1));
        vecs.push_back(mk("rf_x4",        1, 4,1,  0,0,  0,0,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,1));
        vecs.push_back(mk("wr_x10",       1, 0,0,  0,0, 10,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,1));
        vecs.push_back(mk("ma_fwd_x10",   1,10,1,  0,1,  0,0,  0,0,0,        1,10,32'hAA55, 0, 1, FWD_MA,32'hAA55,   FWD_RF,0,     1,1));
        vecs.push_back(mk("x0_read",      1, 0,1,  0,1,  0,1,  0,0,0,        0,0,0,         0, 1, FWD_RF,0,          FWD_RF,0,     0,1));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            push_exp(vecs[i]);
            @(negedge clk);
            compare_head();
        end
        check("queue_drained", 32'(expq.size()), 32'd0);

        // Stalls occurred in raw_x5_stall, full_x3, full_x3_hold and flush.
        @(posedge clk);
        #1;
        drive(idle);
        @(negedge clk);
        check("stall_cnt_total", sbi.stall_cnt, 32'd4);

        // Reset while x6 is pending and its consumer is stalled.
        @(posedge clk);
        #1;
        drive(mk("wr_x6", 1, 0,0, 0,0, 6,1, 0,0,0, 0,0,0, 0, 1, FWD_RF,0, FWD_RF,0, 0,1));
        @(posedge clk);
        #1;
        drive(mk("use_x6", 1, 6,1, 0,0, 0,0, 0,0,0, 0,0,0, 0, 0, FWD_RF,0, FWD_RF,0, 1,1));
        @(negedge clk);
        check("pre_rst.stall", 32'(sbi.id_stall), 32'd1);
        check("pre_rst.busy",  32'(sbi.busy),     32'd1);
        #1;
        rst = 1'b1;
        sbi.ex_ack = 1'b1;
        sbi.ex_idx = 5'd6;
        sbi.ex_val = 32'h66;
        #1;
        check("in_rst.busy",      32'(sbi.busy),     32'd0);
        check("in_rst.err",       32'(sbi.err),      32'd0);
        check("in_rst.stall_cnt", sbi.stall_cnt,     32'd0);
        check("in_rst.issue",     32'(sbi.id_issue), 32'd1);
        check("in_rst.stall",     32'(sbi.id_stall), 32'd0);
        check("in_rst.sel1",      32'(sbi.fwd_sel1), 32'(FWD_RF));
        check("in_rst.val1",      sbi.fwd_val1,      32'd0);
        @(posedge clk);
        #1;
        sbi.ex_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst.issue",     32'(sbi.id_issue), 32'd1);
        check("post_rst.sel1",      32'(sbi.fwd_sel1), 32'(FWD_RF));
        check("post_rst.busy",      32'(sbi.busy),     32'd0);
        check("post_rst.err",       32'(sbi.err),      32'd0);
        check("post_rst.stall_cnt", sbi.stall_cnt,     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1);
    end
endmodule
